muldiv_seq: RTL and testbench

- Iterative sequencer for the RV32M multiply/divide operations (OP opcode, funct7 = 1) that the main decoder does not handle in the single-cycle ALU.
- Accepts one operation at a time from the decode/execute stage through a valid/ready request port.
- Runs a radix-2 shift-add multiply or restoring divide over XLEN cycles, applies sign fix-up, then holds the result on a valid/ready response port.
- The pipeline stalls on busy; kill aborts an in-flight operation on a flush.

---
 rtl/muldiv_seq.sv | 105 ++++++++++
 tb/tb_muldiv_seq.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV32M multiply/divide unit, XLEN cycles of shift-add or restoring divide.
module muldiv_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            req_valid,
    output logic            req_ready,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] op_a,
    input  logic [XLEN-1:0] op_b,
    input  logic            kill,
    output logic            resp_valid,
    input  logic            resp_ready,
    output logic [XLEN-1:0] resp_data,
    output logic            busy
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t state, state_nx;
    logic [CW-1:0] cnt;
    logic [2:0] op;
    logic neg;
    logic [XLEN-1:0] opd;
    logic [2*XLEN-1:0] acc;

    logic accept, signed_a, signed_b, neg_a, neg_b, div_zero, ovf, special, last, ge;
    logic [XLEN-1:0] mag_a, mag_b, special_res, dsel, dres, fix_res;
    logic [XLEN:0] sum, sh;
    logic [2*XLEN-1:0] mul_nx, div_nx, prod;

    assign req_ready  = state == IDLE;
    assign busy       = state != IDLE;
    assign resp_valid = state == DONE;
    assign accept     = req_ready & req_valid & ~kill;
    assign last       = cnt == CW'(XLEN - 1);

    assign signed_a    = funct3[2] ? ~funct3[0] : funct3 != 3'd3;
    assign signed_b    = funct3[2] ? ~funct3[0] : ~funct3[1];
    assign neg_a       = signed_a & op_a[XLEN-1];
    assign neg_b       = signed_b & op_b[XLEN-1];
    assign mag_a       = neg_a ? -op_a : op_a;
    assign mag_b       = neg_b ? -op_b : op_b;
    assign div_zero    = funct3[2] & (op_b == '0);
    assign ovf         = funct3[2] & ~funct3[0] & (op_a == {1'b1, {(XLEN-1){1'b0}}}) & (&op_b);
    assign special     = div_zero | ovf;
    assign special_res = div_zero ? (funct3[1] ? op_a : '1) : (funct3[1] ? '0 : op_a);

    // Multiply: acc = {partial sum, remaining multiplier}; divide: acc = {remainder, dividend/quotient}
    assign sum    = {1'b0, acc[2*XLEN-1:XLEN]} + (acc[0] ? {1'b0, opd} : '0);
    assign mul_nx = {sum, acc[XLEN-1:1]};
    assign sh     = acc[2*XLEN-1:XLEN-1];
    assign ge     = sh >= {1'b0, opd};
    assign div_nx = {ge ? sh[XLEN-1:0] - opd : sh[XLEN-1:0], acc[XLEN-2:0], ge};

    assign prod    = neg ? -acc : acc;
    assign dsel    = op[1] ? acc[2*XLEN-1:XLEN] : acc[XLEN-1:0];
    assign dres    = neg ? -dsel : dsel;
    assign fix_res = op[2] ? dres : (op[1:0] == 2'd0 ? prod[XLEN-1:0] : prod[2*XLEN-1:XLEN]);

    always_ff @(posedge clk)
        state <= reset_n ? state_nx : IDLE;

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    state_nx = accept ? (special ? DONE : CALC) : IDLE;
            CALC:    state_nx = kill ? IDLE : (last ? FIX : CALC);
            FIX:     state_nx = kill ? IDLE : DONE;
            DONE:    state_nx = (kill | resp_ready) ? IDLE : DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc       <= '0;
            opd       <= '0;
            op        <= '0;
            neg       <= 1'b0;
            cnt       <= '0;
            resp_data <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    op  <= funct3;
                    neg <= (funct3[2] & funct3[1]) ? neg_a : neg_a ^ neg_b;
                    cnt <= '0;
                    opd <= funct3[2] ? mag_b : mag_a;
                    acc <= {{XLEN{1'b0}}, funct3[2] ? mag_a : mag_b};
                    if (special)
                        resp_data <= special_res;
                end
                CALC: begin
                    acc <= op[2] ? div_nx : mul_nx;
                    cnt <= cnt + 1'b1;
                end
                FIX: resp_data <= fix_res;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq: directed vectors, control-path sequences and randomized ops against a 64-bit arithmetic model.
`timescale 1ns/1ps
module tb_muldiv_seq;
    logic        clk = 1'b0;
    logic        reset_n, req_valid, req_ready, kill, resp_valid, resp_ready, busy;
    logic [2:0]  funct3;
    logic [31:0] op_a, op_b, resp_data;
    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [2:0]  f3;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
        logic [7:0]  lat;
    } vec_t;

    vec_t vt[18];

    muldiv_seq #(.XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_ready(req_ready),
        .funct3(funct3), .op_a(op_a), .op_b(op_b), .kill(kill),
        .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_data(resp_data), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb;
        longint unsigned ua, ub;
        logic [63:0] p;
        logic ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = {32'd0, a};
        ub  = {32'd0, b};
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = '0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0]; end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * longint'(ub); return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: return (b == 0) ? 32'hFFFF_FFFF : ovf ? 32'h8000_0000 : 32'(sa / sb);
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : 32'(ua / ub);
            3'd6: return (b == 0) ? a : ovf ? 32'd0 : 32'(sa % sb);
            default: return (b == 0) ? a : 32'(ua % ub);
        endcase
    endfunction

    function automatic int model_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)))
            return 1;
        return 34;
    endfunction

    function automatic logic [31:0] rnd_opnd();
        case ($urandom_range(0, 5))
            0: return 32'd0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 15));
            default: return $urandom;
        endcase
    endfunction

    // Latency counts the accept edge as edge 1.
    task automatic run_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                          input int hold, output logic [31:0] res, output int lat);
        logic busy_bad, unstable;
        logic [31:0] held;
        busy_bad   = 1'b0;
        unstable   = 1'b0;
        funct3     = f;
        op_a       = a;
        op_b       = b;
        req_valid  = 1'b1;
        resp_ready = (hold == 0);
        @(posedge clk); #1;
        req_valid = 1'b0;
        op_a      = $urandom;
        op_b      = $urandom;
        funct3    = 3'($urandom);
        lat       = 1;
        while (!resp_valid && lat < 60) begin
            if (!busy) busy_bad = 1'b1;
            @(posedge clk); #1;
            lat++;
        end
        res  = resp_data;
        held = resp_data;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            if (!resp_valid || resp_data !== held || req_ready || !busy) unstable = 1'b1;
        end
        resp_ready = 1'b1;
        @(posedge clk); #1;
        resp_ready = 1'b0;
        check("busy during op", {31'd0, busy_bad}, 32'd0);
        check("resp held stable", {31'd0, unstable}, 32'd0);
        check("release to idle", {30'd0, resp_valid, req_ready}, 32'd1);
    endtask

    task automatic no_resp_for(input string name, input int n);
        logic seen;
        seen = 1'b0;
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            if (resp_valid) seen = 1'b1;
        end
        check(name, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        logic [31:0] res, a, b;
        logic [2:0] f;
        int lat;
        vt[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 8'd34};
        vt[1]  = '{3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 8'd34};
        vt[2]  = '{3'd2, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 8'd34};
        vt[3]  = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 8'd34};
        vt[4]  = '{3'd4, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFD, 8'd34};
        vt[5]  = '{3'd6, 32'hFFFF_FFF9,  32'd2,         32'hFFFF_FFFF, 8'd34};
        vt[6]  = '{3'd5, 32'd100,        32'd7,         32'd14,        8'd34};
        vt[7]  = '{3'd7, 32'd100,        32'd7,         32'd2,         8'd34};
        vt[8]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 8'd1};
        vt[9]  = '{3'd7, 32'd5,          32'd0,         32'd5,         8'd1};
        vt[10] = '{3'd4, 32'h8000_0000,  32'hFFFF_FFFF, 32'h8000_0000, 8'd1};
        vt[11] = '{3'd6, 32'h8000_0000,  32'hFFFF_FFFF, 32'd0,         8'd1};
        vt[12] = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 8'd1};
        vt[13] = '{3'd6, 32'd5,          32'd0,         32'd5,         8'd1};
        vt[14] = '{3'd0, 32'd0,          32'h1234_5678, 32'd0,         8'd34};
        vt[15] = '{3'd5, 32'hFFFF_FFFF,  32'd1,         32'hFFFF_FFFF, 8'd34};
        vt[16] = '{3'd6, 32'hFFFF_FFF8,  32'hFFFF_FFFD, 32'hFFFF_FFFE, 8'd34};
        vt[17] = '{3'd4, 32'hFFFF_FFF8,  32'hFFFF_FFFD, 32'd2,         8'd34};

        reset_n = 1'b0; req_valid = 1'b0; kill = 1'b0; resp_ready = 1'b0;
        funct3 = 3'd0; op_a = '0; op_b = '0;
        repeat (2) @(posedge clk);
        #1;
        check("reset req_ready", {31'd0, req_ready}, 32'd1);
        check("reset resp_valid", {31'd0, resp_valid}, 32'd0);
        check("reset resp_data", resp_data, 32'd0);
        check("reset busy", {31'd0, busy}, 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        for (int i = 0; i < 18; i++) begin
            run_op(vt[i].f3, vt[i].a, vt[i].b, 0, res, lat);
            check($sformatf("vec%0d data", i), res, vt[i].exp);
            check($sformatf("vec%0d latency", i), 32'(lat), {24'd0, vt[i].lat});
        end

        run_op(3'd4, 32'd1000, 32'd7, 10, res, lat);
        check("backpressure data", res, 32'd142);

        // Kill during CALC, then confirm the unit is clean for the next op
        funct3 = 3'd0; op_a = 32'd9; op_b = 32'd9; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        kill = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0;
        check("kill busy", {31'd0, busy}, 32'd0);
        check("kill req_ready", {31'd0, req_ready}, 32'd1);
        no_resp_for("kill no resp", 40);
        run_op(3'd1, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 0, res, lat);
        check("after kill data", res, 32'h3FFF_FFFF);

        // Kill in DONE with resp_ready asserted: response dropped
        funct3 = 3'd4; op_a = 32'd5; op_b = 32'd0; req_valid = 1'b1; resp_ready = 1'b0;
        @(posedge clk); #1;
        req_valid = 1'b0;
        check("done before kill", {31'd0, resp_valid}, 32'd1);
        kill = 1'b1; resp_ready = 1'b1;
        @(posedge clk); #1;
        kill = 1'b0; resp_ready = 1'b0;
        check("kill in done", {30'd0, resp_valid, busy}, 32'd0);

        // Kill in IDLE blocks a concurrent request
        funct3 = 3'd0; op_a = 32'd3; op_b = 32'd3; req_valid = 1'b1; kill = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0; kill = 1'b0;
        check("kill in idle", {31'd0, busy}, 32'd0);

        // Reset mid-CALC
        funct3 = 3'd5; op_a = 32'd77; op_b = 32'd3; req_valid = 1'b1;
        @(posedge clk); #1;
        req_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        reset_n = 1'b0;
        @(posedge clk); #1;
        check("midreset outputs", {resp_data[28:0], req_ready, resp_valid, busy}, 32'd4);
        reset_n = 1'b1;
        no_resp_for("midreset no resp", 40);

        for (int n = 0; n < 200; n++) begin
            f = 3'($urandom);
            a = rnd_opnd();
            b = rnd_opnd();
            run_op(f, a, b, $urandom_range(0, 3), res, lat);
            check($sformatf("rnd%0d f%0d %h,%h data", n, f, a, b), res, model(f, a, b));
            check($sformatf("rnd%0d latency", n), 32'(lat), 32'(model_lat(f, a, b)));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
